// File: rtl/data_mem_pipe.sv
// data_mem_pipe: single-port, word-addressed data memory for the ToyMIPS MEM stage.
// Request/ready handshake, byte-lane write strobes, RD_LAT-cycle read pipeline with
// rvalid, post-reset zero-clear sweep and an out-of-range flag.
// Optional feature: define DMEM_PARITY_EN to store and check one even-parity bit per byte.
module data_mem_pipe #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 16,
  parameter int RD_LAT       = 1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                ready_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                perr_o
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [IDX_W-1:0]   idx_s;
  logic               oor_s, acc_s, wr_s, clr_wr_s;
  logic [DATA_W-1:0]  rd_word_s;
  logic               rd_perr_s;

  logic               rd_vld_d, rd_perr_d;
  logic [DATA_W-1:0]  rd_dat_d;
  logic [RD_LAT-1:0]  vld_q, perr_q;
  logic [DATA_W-1:0]  dat_q [RD_LAT];
  logic               err_q;

  assign idx_s     = addr_i[IDX_W-1:0];
  assign oor_s     = (addr_i >> IDX_W) != {ADDR_W{1'b0}};
  assign ready_o   = (state_q == S_RUN);
  // A reset edge wins over any request presented on the same edge.
  assign acc_s     = req_i & ready_o & ~rst_i;
  assign wr_s      = acc_s & we_i & ~oor_s;
  assign clr_wr_s  = (state_q == S_CLEAR) & ~rst_i;
  assign rd_word_s = oor_s ? {DATA_W{1'b0}} : mem_q[idx_s];

  // FSM state and sweep pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR_ON_RST ? S_CLEAR : S_RUN;
      clr_ptr_q <= {IDX_W{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state: sweep every word once, then serve requests forever
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == PTR_LAST) begin
          state_d = S_RUN;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_RUN: begin
        state_d   = S_RUN;
        clr_ptr_d = {IDX_W{1'b0}};
      end
      default: begin
        state_d   = CLEAR_ON_RST ? S_CLEAR : S_RUN;
        clr_ptr_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Data array: sweep clear has priority, otherwise byte-masked writes
  always_ff @(posedge clk_i) begin
    if (clr_wr_s) begin
      mem_q[clr_ptr_q] <= {DATA_W{1'b0}};
    end else if (wr_s) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) begin
          mem_q[idx_s][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    p = {NB{1'b0}};
    for (int k = 0; k < NB; k++) begin
      p[k] = ^w[8*k +: 8];
    end
    return p;
  endfunction

  // Parity array: tracks the data array write-for-write, one bit per byte lane
  always_ff @(posedge clk_i) begin
    if (clr_wr_s) begin
      par_q[clr_ptr_q] <= {NB{1'b0}};
    end else if (wr_s) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) begin
          par_q[idx_s][k] <= ^wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rd_perr_s = ~oor_s & (byte_parity(mem_q[idx_s]) != par_q[idx_s]);
`else
  assign rd_perr_s = 1'b0;
`endif

  // First read stage contents; data is zeroed unless a read was accepted
  always_comb begin
    rd_vld_d  = acc_s & ~we_i;
    rd_dat_d  = {DATA_W{1'b0}};
    rd_perr_d = 1'b0;
    if (rd_vld_d) begin
      rd_dat_d  = rd_word_s;
      rd_perr_d = rd_perr_s;
    end else begin
      rd_dat_d  = {DATA_W{1'b0}};
      rd_perr_d = 1'b0;
    end
  end

  // Read pipeline and error pulse; reset flushes every in-flight read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= {RD_LAT{1'b0}};
      perr_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= {DATA_W{1'b0}};
      end
      err_q  <= 1'b0;
    end else begin
      vld_q[0]  <= rd_vld_d;
      dat_q[0]  <= rd_dat_d;
      perr_q[0] <= rd_perr_d;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        dat_q[i]  <= dat_q[i-1];
        perr_q[i] <= perr_q[i-1];
      end
      err_q <= acc_s & oor_s;
    end
  end

  assign rvalid_o = vld_q[RD_LAT-1];
  assign rdata_o  = dat_q[RD_LAT-1];
  assign perr_o   = perr_q[RD_LAT-1];
  assign err_o    = err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: randomized, model-checked bench for data_mem_pipe plus directed cases.
module tb_data_mem_pipe;

  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int AW = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst, req, we;
  logic [3:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic ready_o, rvalid_o, err_o, perr_o;
  logic [DW-1:0] rdata_o;

  int n_chk = 0;
  int n_fail = 0;

  data_mem_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(LAT), .CLEAR_ON_RST(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .perr_o(perr_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] d;
    bit          pe;
  } rd_t;

  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_bad [DEPTH];
  rd_t         pq[$];
  rd_t         ent;
  int          clear_left = 0;
  int          edge_n = 0;
  bit          started = 1'b0;
  bit          m_acc, m_oor;
  bit          e_rvalid, e_err, e_perr;
  logic [31:0] e_rdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: memory contents, sweep length and queue of reads due at a given edge
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      started = 1'b1;
      clear_left = DEPTH;
      pq.delete();
      e_err = 1'b0; e_rvalid = 1'b0; e_rdata = 32'h0; e_perr = 1'b0;
    end else if (started) begin
      m_acc = req && (clear_left == 0);
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 32'h0;
            m_bad[i] = 4'h0;
          end
        end
      end
      m_oor = (addr >= DEPTH);
      e_err = m_acc && m_oor;
      if (m_acc && we && !m_oor) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) begin
            m_mem[addr][8*k +: 8] = wdata[8*k +: 8];
            m_bad[addr][k] = 1'b0;
          end
        end
      end
      if (m_acc && !we) begin
        ent.due = edge_n + LAT - 1;
        ent.d   = m_oor ? 32'h0 : m_mem[addr];
        ent.pe  = !m_oor && (m_bad[addr] != 4'h0);
        pq.push_back(ent);
      end
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        e_rvalid = 1'b1; e_rdata = pq[0].d; e_perr = pq[0].pe;
        void'(pq.pop_front());
      end else begin
        e_rvalid = 1'b0; e_rdata = 32'h0; e_perr = 1'b0;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (started) begin
      check("ready", {31'h0, ready_o}, {31'h0, clear_left == 0});
      check("rvalid", {31'h0, rvalid_o}, {31'h0, e_rvalid});
      check("rdata", rdata_o, e_rdata);
      check("err", {31'h0, err_o}, {31'h0, e_err});
      check("perr", {31'h0, perr_o}, {31'h0, e_perr});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit r, input bit w, input logic [3:0] b,
                       input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b0; req = r; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (!ready_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) check({nm, "_timeout"}, 32'h0, 32'h1);
  endtask

  // Read one word and check the literal result at exactly LAT cycles
  task automatic read_chk(input logic [15:0] a, input logic [31:0] exp_d,
                          input bit exp_err, input bit exp_pe, input string nm);
    drive(1'b1, 1'b0, 4'h0, a, 32'h0);
    idle();
    check({nm, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    check({nm, "_early1"}, {31'h0, rvalid_o}, 32'h0);
    idle();
    check({nm, "_early2"}, {31'h0, rvalid_o}, 32'h0);
    idle();
    check({nm, "_rvalid"}, {31'h0, rvalid_o}, 32'h1);
    check({nm, "_rdata"}, rdata_o, exp_d);
    check({nm, "_perr"}, {31'h0, perr_o}, {31'h0, exp_pe});
  endtask

  int n;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 16'h0; wdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    // T1: sweep length and cleared contents
    wait_ready("t1", n);
    check("t1_clear_len", n, 32'd256);
    read_chk(16'h0055, 32'h0, 1'b0, 1'b0, "t1_rd55");

    // T2: write then read-after-write, latency 3
    drive(1'b1, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF);
    read_chk(16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, "t2");

    // T3: byte-lane merge
    drive(1'b1, 1'b1, 4'hF, 16'h0020, 32'hAABBCCDD);
    drive(1'b1, 1'b1, 4'b0101, 16'h0020, 32'h11223344);
    read_chk(16'h0020, 32'hAA22CC44, 1'b0, 1'b0, "t3");
    drive(1'b1, 1'b1, 4'h0, 16'h0020, 32'hFFFFFFFF);
    read_chk(16'h0020, 32'hAA22CC44, 1'b0, 1'b0, "t3_be0");

    // T5: out-of-range write and read
    drive(1'b1, 1'b1, 4'hF, 16'h0000, 32'h12345678);
    drive(1'b1, 1'b1, 4'hF, 16'h0100, 32'hFFFFFFFF);
    idle();
    check("t5_wr_err", {31'h0, err_o}, 32'h1);
    read_chk(16'h0000, 32'h12345678, 1'b0, 1'b0, "t5_mem0");
    read_chk(16'h0100, 32'h0, 1'b1, 1'b0, "t5_oor");

    // T4: back-to-back reads, then reset mid-burst
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 4'hF, 16'(i), 32'hC0DE0000 + i);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 4'h0, 16'(i), 32'h0);
      else idle();
      if (i >= 3) begin
        check("t4_burst_rvalid", {31'h0, rvalid_o}, 32'h1);
        check("t4_burst_rdata", rdata_o, 32'hC0DE0000 + (i - 3));
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'h0, 16'(i), 32'h0);
    check("t4_pre_rst", rdata_o, 32'hC0DE0000);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    check("t4_last_before_rst", rdata_o, 32'hC0DE0001);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_flushed", {31'h0, rvalid_o}, 32'h0);
      @(negedge clk);
    end
    wait_ready("t4", n);
    read_chk(16'h0010, 32'h0, 1'b0, 1'b0, "t4_cleared");

`ifdef DMEM_PARITY_EN
    // T6: corrupted stored parity is reported, data returned unmodified
    drive(1'b1, 1'b1, 4'hF, 16'h0005, 32'h01020304);
    idle();
    dut.par_q[5][0] = ~dut.par_q[5][0];
    m_bad[5][0] = 1'b1;
    read_chk(16'h0005, 32'h01020304, 1'b0, 1'b1, "t6_bad");
    drive(1'b1, 1'b1, 4'hF, 16'h0006, 32'h01020304);
    read_chk(16'h0006, 32'h01020304, 1'b0, 1'b0, "t6_good");
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; req = 1'b0;
      end else begin
        rst   = 1'b0;
        req   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1) == 1;
        be    = 4'($urandom());
        addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                            : 16'($urandom_range(0, 31));
        wdata = $urandom();
      end
    end
    idle();
    for (int i = 0; i < LAT + 2; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
